// File: rtl/cfu_pkg.sv
// Shared widths, FSM state encoding and queue entry layouts for the CFU initiator.
package cfu_pkg;

  localparam int FUNC_ID_W = 10;
  localparam int DATA_W    = 32;
  localparam int WDOG_W    = 16;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } cfu_state_e;

  typedef struct packed {
    logic [FUNC_ID_W-1:0] function_id;
    logic [DATA_W-1:0]    inputs_0;
    logic [DATA_W-1:0]    inputs_1;
  } cfu_req_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } cfu_res_t;

  localparam int REQ_W = $bits(cfu_req_t);
  localparam int RES_W = $bits(cfu_res_t);

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head visible while non-empty, push ignored when full.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW:0]                 r_wr_ptr;
  logic [AW:0]                 r_rd_ptr;
  logic                        w_push;
  logic                        w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Storage is cleared too so the head never shows stale flags after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cfu_initiator.sv
// Queues host requests, issues one CFU command at a time and queues the results.
// Define CFU_INITIATOR_TIMEOUT_EN to abort a stuck command after TIMEOUT_CYCLES.
module cfu_initiator
  import cfu_pkg::*;
#(
  parameter int REQ_DEPTH      = 4,
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [FUNC_ID_W-1:0] i_req_function_id,
  input  logic [DATA_W-1:0]    i_req_inputs_0,
  input  logic [DATA_W-1:0]    i_req_inputs_1,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ready,
  output logic [FUNC_ID_W-1:0] o_cmd_payload_function_id,
  output logic [DATA_W-1:0]    o_cmd_payload_inputs_0,
  output logic [DATA_W-1:0]    o_cmd_payload_inputs_1,
  input  logic                 i_rsp_valid,
  output logic                 o_rsp_ready,
  input  logic [DATA_W-1:0]    i_rsp_payload_outputs_0,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [DATA_W-1:0]    o_res_data,
  output logic                 o_res_err,
  output logic                 o_busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cfu_initiator: TIMEOUT_CYCLES must be within 1..65535");
  end

  cfu_state_e r_state;
  cfu_state_e w_state_nxt;
  logic       r_live;
  cfu_req_t   r_cmd;

  cfu_req_t   w_req_push_dat;
  cfu_req_t   w_req_head;
  logic       w_req_push;
  logic       w_req_pop;
  logic       w_req_full;
  logic       w_req_empty;

  cfu_res_t   w_res_push_dat;
  cfu_res_t   w_res_head;
  logic       w_res_push;
  logic       w_res_full;
  logic       w_res_empty;

  logic       w_active;
  logic       w_cmd_fire;
  logic       w_rsp_fire;
  logic       w_timeout;

  assign w_req_push_dat = '{function_id: i_req_function_id,
                            inputs_0:    i_req_inputs_0,
                            inputs_1:    i_req_inputs_1};
  assign w_req_push     = i_req_valid && o_req_ready;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_q (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_req_push),
    .i_push_data (w_req_push_dat),
    .i_pop       (w_req_pop),
    .o_head      (w_req_head),
    .o_full      (w_req_full),
    .o_empty     (w_req_empty)
  );

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_q (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_res_push),
    .i_push_data (w_res_push_dat),
    .i_pop       (i_res_ready),
    .o_head      (w_res_head),
    .o_full      (w_res_full),
    .o_empty     (w_res_empty)
  );

  assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_WAIT_RSP);
  assign o_cmd_valid = (r_state == ST_ISSUE);
  // Response side stays open during ISSUE so a CFU tying cmd_ready to rsp_ready cannot lock up.
  assign o_rsp_ready = w_active && !w_res_full;
  assign w_cmd_fire  = o_cmd_valid && i_cmd_ready;
  assign w_rsp_fire  = i_rsp_valid && o_rsp_ready;

  assign o_req_ready = r_live && !w_req_full;
  assign o_res_valid = !w_res_empty;
  assign o_res_data  = w_res_head.data;
  assign o_res_err   = w_res_head.err;
  assign o_busy      = (r_state != ST_IDLE) || !w_req_empty || !w_res_empty;

  assign o_cmd_payload_function_id = r_cmd.function_id;
  assign o_cmd_payload_inputs_0    = r_cmd.inputs_0;
  assign o_cmd_payload_inputs_1    = r_cmd.inputs_1;

`ifdef CFU_INITIATOR_TIMEOUT_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              w_wdog_en;

  // Time spent blocked on a full result queue is not charged to the CFU.
  assign w_wdog_en = w_active && !w_res_full;
  assign w_timeout = w_wdog_en && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog <= '0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_wdog <= '0;
    end else if (w_wdog_en) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_req_pop      = 1'b0;
    w_res_push     = 1'b0;
    w_res_push_dat = '{err: 1'b0, data: i_rsp_payload_outputs_0};
    case (r_state)
      ST_IDLE: begin
        if (!w_req_empty) begin
          w_req_pop   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_cmd_fire && w_rsp_fire) begin
          w_res_push  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_cmd_fire) begin
          w_state_nxt = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (w_rsp_fire) begin
          w_res_push  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // A real response in the expiry cycle wins over the synthetic error result.
    if (w_timeout && !w_res_push) begin
      w_res_push     = 1'b1;
      w_res_push_dat = '{err: 1'b1, data: TIMEOUT_DATA};
      w_state_nxt    = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_cmd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_req_pop) begin
        r_cmd <= w_req_head;
      end
    end
  end

endmodule

// File: tb/tb_cfu_initiator.sv
// Scoreboarded bench: directed requests against a small behavioural CFU with selectable timing.
module tb_cfu_initiator;
  import cfu_pkg::*;

  localparam int REQ_DEPTH = 4;
  localparam int RES_DEPTH = 4;
`ifdef CFU_INITIATOR_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 8;
`else
  localparam int TIMEOUT_CYCLES = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_fid = '0;
  logic [31:0] req_in0 = '0;
  logic [31:0] req_in1 = '0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_fid;
  logic [31:0] cmd_in0;
  logic [31:0] cmd_in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] sb_q[$];
  logic [32:0] mon_exp;
  // 0: combinational echo of in1, cmd_ready tied to rsp_ready
  // 1: accepts, answers in0+in1 three cycles later
  // 2: never ready; 3: accepts but never answers
  int          cfu_mode = 0;
  logic [1:0]  dly_cnt;
  logic [31:0] dly_dat;
  int          n;
  int          g;

  always #5 clk = ~clk;

  cfu_initiator #(
    .REQ_DEPTH      (REQ_DEPTH),
    .RES_DEPTH      (RES_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_req_valid               (req_valid),
    .o_req_ready               (req_ready),
    .i_req_function_id         (req_fid),
    .i_req_inputs_0            (req_in0),
    .i_req_inputs_1            (req_in1),
    .o_cmd_valid               (cmd_valid),
    .i_cmd_ready               (cmd_ready),
    .o_cmd_payload_function_id (cmd_fid),
    .o_cmd_payload_inputs_0    (cmd_in0),
    .o_cmd_payload_inputs_1    (cmd_in1),
    .i_rsp_valid               (rsp_valid),
    .o_rsp_ready               (rsp_ready),
    .i_rsp_payload_outputs_0   (rsp_data),
    .o_res_valid               (res_valid),
    .i_res_ready               (res_ready),
    .o_res_data                (res_data),
    .o_res_err                 (res_err),
    .o_busy                    (busy)
  );

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    case (cfu_mode)
      0: begin
        cmd_ready = rsp_ready;
        rsp_valid = cmd_valid;
        rsp_data  = cmd_in1;
      end
      1: begin
        cmd_ready = (dly_cnt == 2'd0);
        rsp_valid = (dly_cnt == 2'd1);
        rsp_data  = dly_dat;
      end
      3: cmd_ready = 1'b1;
      default: ;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
      dly_dat <= '0;
    end else if (cfu_mode == 1) begin
      if (cmd_valid && cmd_ready) begin
        dly_cnt <= 2'd3;
        dly_dat <= cmd_in0 + cmd_in1;
      end else if (dly_cnt > 2'd1) begin
        dly_cnt <= dly_cnt - 2'd1;
      end else if (dly_cnt == 2'd1 && rsp_ready) begin
        dly_cnt <= 2'd0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result the host accepts must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got err=%0d data=0x%0h with nothing expected", res_err, res_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({res_err, res_data} !== mon_exp) begin
          failures++;
          $display("FAIL result: got err=%0d data=0x%0h expected err=%0d data=0x%0h",
                   res_err, res_data, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  // Entered and left just after a rising edge; returns right after the transfer edge.
  task automatic push_req(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_res, input logic [32:0] exp);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_fid   = f;
    req_in0   = a;
    req_in1   = b;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: req_ready stayed 0 for fid=%0d, required 1", f);
    end else if (expect_res) begin
      sb_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    check({tag, "_drained"}, sb_q.size(), 0);
    @(negedge clk);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_res_valid_low"}, res_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_rsp_ready"}, rsp_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_fid"}, cmd_fid, 0);
    check({tag, "_cmd_in0"}, cmd_in0, 0);
    check({tag, "_cmd_in1"}, cmd_in1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("req_ready_after_reset", req_ready, 1);
    @(posedge clk);
    #1;

    // Single request latency through an echoing CFU.
    cfu_mode  = 0;
    res_ready = 1'b1;
    push_req(10'd1, 32'h11, 32'h22, 1'b1, {1'b0, 32'h22});
    @(negedge clk);
    check("lat_n1_cmd_valid", cmd_valid, 0);
    @(negedge clk);
    check("lat_n2_cmd_valid", cmd_valid, 1);
    check("lat_n2_cmd_fid", cmd_fid, 1);
    check("lat_n2_cmd_in0", cmd_in0, 32'h11);
    check("lat_n2_cmd_in1", cmd_in1, 32'h22);
    check("lat_n2_res_valid", res_valid, 0);
    @(negedge clk);
    check("lat_n3_res_valid", res_valid, 1);
    check("lat_n3_res_data", res_data, 32'h22);
    check("lat_n3_res_err", res_err, 0);
    wait_drain("lat");

    // Fill the request queue behind a command the CFU refuses, then release it.
    cfu_mode = 2;
    push_req(10'd2, 32'h1, 32'hA0, 1'b1, {1'b0, 32'hA0});
    for (int i = 1; i <= 4; i++) begin
      push_req(10'd2, 32'(i), 32'(32'hB0 + i), 1'b1, {1'b0, 32'(32'hB0 + i)});
    end
    @(negedge clk);
    check("fill_req_ready_low", req_ready, 0);
    check("fill_busy", busy, 1);
    cfu_mode = 0;
    wait_drain("fill");

    // Result queue backpressure: fifth command must hold in ISSUE.
    cfu_mode  = 0;
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push_req(10'd3, 32'(i), 32'(32'hC0 + i), 1'b1, {1'b0, 32'(32'hC0 + i)});
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("bp_res_valid", res_valid, 1);
    check("bp_rsp_ready", rsp_ready, 0);
    check("bp_cmd_valid", cmd_valid, 1);
    check("bp_cmd_fid", cmd_fid, 3);
    check("bp_cmd_in0", cmd_in0, 32'h5);
    check("bp_cmd_in1", cmd_in1, 32'hC5);
    repeat (3) @(negedge clk);
    check("bp_hold_cmd_valid", cmd_valid, 1);
    check("bp_hold_cmd_in1", cmd_in1, 32'hC5);
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_released_cmd_valid", cmd_valid, 0);
    check("bp_released_res_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_drain("bp");

    // Slow CFU: three cycles in WAIT_RSP before the answer.
    cfu_mode = 1;
    push_req(10'd4, 32'h100, 32'h23, 1'b1, {1'b0, 32'h123});
    n = 0;
    g = 0;
    @(negedge clk);
    while (!res_valid && g < 30) begin
      if (rsp_ready && !cmd_valid) n++;
      g++;
      @(negedge clk);
    end
    check("slow_wait_cycles", n, 3);
    check("slow_res_valid", res_valid, 1);
    wait_drain("slow");

`ifdef CFU_INITIATOR_TIMEOUT_EN
    // Dead CFU: watchdog produces the error result.
    cfu_mode = 2;
    push_req(10'd5, 32'h1, 32'h2, 1'b1, {1'b1, 32'hFFFF_FFFF});
    n = 0;
    g = 0;
    @(negedge clk);
    while (g < 60 && !(n > 0 && !cmd_valid)) begin
      if (cmd_valid) n++;
      g++;
      @(negedge clk);
    end
    check("wdog_issue_cycles", n, TIMEOUT_CYCLES);
    check("wdog_res_valid", res_valid, 1);
    check("wdog_rsp_ready", rsp_ready, 0);
    wait_drain("wdog");
`endif

    // Reset while waiting on a response with two requests still queued.
    cfu_mode = 3;
    for (int i = 1; i <= 3; i++) begin
      push_req(10'd6, 32'(i), 32'(32'hD0 + i), 1'b0, '0);
    end
    @(negedge clk);
    check("mid_pre_rsp_ready", rsp_ready, 1);
    check("mid_pre_cmd_valid", cmd_valid, 0);
    check("mid_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cfu_mode = 0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid || cmd_valid) n++;
    end
    check("mid_post_activity", n, 0);
    check("mid_post_req_ready", req_ready, 1);
    check("mid_post_busy", busy, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfu_initiator.md
CFU_INITIATOR -- requirements
Module: cfu_initiator

Interface
REQ-001 Parameter REQ_DEPTH, default 4: request queue depth in entries, power of two, minimum 2.
REQ-002 Parameter RES_DEPTH, default 4: result queue depth in entries, power of two, minimum 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, range 1..65535.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  host request handshake.
REQ-007 req_function_id / req_inputs_0 / req_inputs_1  in  10 / 32 / 32  request payload.
REQ-008 cmd_valid / cmd_ready  out / in  1 / 1  CFU command handshake.
REQ-009 cmd_payload_function_id / cmd_payload_inputs_0 / cmd_payload_inputs_1  out  10 / 32 / 32  command payload.
REQ-010 rsp_valid / rsp_ready  in / out  1 / 1  CFU response handshake.
REQ-011 rsp_payload_outputs_0  in  32  CFU result.
REQ-012 res_valid / res_ready  out / in  1 / 1  host result handshake.
REQ-013 res_data / res_err  out  32 / 1  result word; error flag.
REQ-014 busy  out  1  high when state != IDLE or either queue is non-empty.

Function
REQ-015 A transfer on any channel SHALL occur only on a clock edge where valid and ready are both high.
REQ-016 req_ready SHALL equal "request queue not full"; res_valid SHALL equal "result queue not empty"; res_data and res_err SHALL come from the result queue head.
REQ-017 FSM states: IDLE, ISSUE, WAIT_RSP; at most one command outstanding at a time.
REQ-018 IDLE->ISSUE when the request queue is non-empty: pop the head and register it into the cmd_payload_* registers.
REQ-019 cmd_valid SHALL be high exactly in ISSUE; cmd_payload_* SHALL stay stable from ISSUE entry until the command transfers.
REQ-020 rsp_ready SHALL be high in ISSUE and WAIT_RSP when the result queue is not full, and low otherwise.
REQ-021 rsp_ready is asserted in ISSUE because the CFU may tie cmd_ready to rsp_ready; this SHALL NOT deadlock.
REQ-022 ISSUE, command and response transfer in the same cycle: push the result (res_err=0) and go to IDLE.
REQ-023 ISSUE, command transfer only: go to WAIT_RSP.
REQ-024 WAIT_RSP, response transfer: push the result (res_err=0) and go to IDLE.
REQ-025 rsp_valid outside ISSUE/WAIT_RSP SHALL be ignored, with no push.
REQ-026 Latency with a combinational CFU that is always ready: request transfer at edge N -> cmd_valid high in cycle N+2 -> res_valid high in cycle N+3.
REQ-027 Throughput: one command per 2 cycles (ISSUE then IDLE).
REQ-028 Simultaneous request push on a full queue SHALL be impossible because req_ready is low; a simultaneous pop and push SHALL both take effect.
REQ-029 A full result queue SHALL stall the FSM in place with no data loss; queue pointers SHALL wrap modulo depth.

Reset
REQ-030 When reset is low, asynchronously: state=IDLE; both queues empty; cmd_valid=0; rsp_ready=0; req_ready=0; res_valid=0; res_err=0; busy=0; cmd_payload_*=0; watchdog=0.
REQ-031 req_ready SHALL assert in the first cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL discard any in-flight command and all queued entries; a dropped cmd_valid during reset is permitted.

Configuration
REQ-033 Macro CFU_INITIATOR_TIMEOUT_EN defined: a 16-bit watchdog counts cycles spent in ISSUE or WAIT_RSP while the result queue is not full, and clears on entry to IDLE.
REQ-034 With the macro, when the count reaches TIMEOUT_CYCLES: push res_data=32'hFFFF_FFFF with res_err=1, deassert cmd_valid, go to IDLE, and ignore any late response.
REQ-035 Macro undefined: no watchdog logic; the FSM waits indefinitely; res_err is tied 0.

Structure
REQ-036 Shared package cfu_pkg SHALL hold FUNC_ID_W=10, DATA_W=32, the FSM state enum, and constant TIMEOUT_DATA=32'hFFFF_FFFF.
REQ-037 Sub-module sync_fifo (parameters WIDTH and DEPTH; first-word-fall-through; full/empty flags) SHALL be instantiated twice: request queue WIDTH=74, result queue WIDTH=33.

Verification
REQ-038 Reset, then one request (fid=1, in0=0x11, in1=0x22) with an echoing combinational CFU -> cmd_valid in cycle N+2 -> res_data=0x22, res_err=0 in cycle N+3.
REQ-039 Back-to-back push of 4 requests into REQ_DEPTH=4 -> req_ready low after the 4th; results appear in order; busy falls after the last result is popped.
REQ-040 res_ready held 0 with 5 requests -> 4 results queued; rsp_ready low; the 5th command holds in ISSUE with a stable payload; one result pop -> the 5th result completes.
REQ-041 CFU asserts rsp_valid 3 cycles after the command transfers -> FSM holds WAIT_RSP for 3 cycles, then pushes the result.
REQ-042 CFU_INITIATOR_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, CFU never ready -> after 8 cycles res_data=0xFFFFFFFF, res_err=1, state IDLE.
REQ-043 reset asserted while in WAIT_RSP with 2 requests queued -> all outputs take their REQ-030 values immediately; no result is emitted after release.
